// File: rtl/decoding_mc.sv
// Multi-cycle MIPS control unit: IF/ID/EX/MEM/WB sequencer with per-state datapath
// enables, a ready/timeout handshake on data-memory access and a sticky illegal trap.
module decoding_mc #(
    parameter int ALUCTR_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWr,
    output logic [1:0]          PCSrc,
    output logic                IRWr,
    output logic                RegWr,
    output logic                RegDst,
    output logic                AluSrc,
    output logic                ExtOp,
    output logic                MemtoReg,
    output logic                MemRd,
    output logic                MemWr,
    output logic [ALUCTR_W-1:0] Aluctr,
    output logic                done,
    output logic                illegal,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_BR   = 3'd5,
        S_JMP  = 3'd6,
        S_TRAP = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    function automatic logic rfunc_legal(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_SUBU, F_AND, F_SLT, F_SLTU: rfunc_legal = 1'b1;
            default:                                     rfunc_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] rfunc_alu(input logic [5:0] f);
        case (f)
            F_ADD:   rfunc_alu = 3'b001;
            F_SUB:   rfunc_alu = 3'b101;
            F_SUBU:  rfunc_alu = 3'b100;
            F_AND:   rfunc_alu = 3'b011;
            F_SLT:   rfunc_alu = 3'b111;
            F_SLTU:  rfunc_alu = 3'b110;
            default: rfunc_alu = 3'b000;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] func_q, func_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;

    logic is_r, is_lw, is_sw;
    assign is_r  = (op_q == OP_RTYPE);
    assign is_lw = (op_q == OP_LW);
    assign is_sw = (op_q == OP_SW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IF;
            op_q      <= '0;
            func_q    <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            func_q    <= func_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        func_d  = func_q;
        wait_d  = wait_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                op_d   = op;
                func_d = func;
                case (op)
                    OP_RTYPE:                    state_d = rfunc_legal(func) ? S_EX : S_TRAP;
                    OP_ORI, OP_ADDIU, OP_LW, OP_SW: state_d = S_EX;
                    OP_BEQ:                      state_d = S_BR;
                    OP_J:                        state_d = S_JMP;
                    default:                     state_d = S_TRAP;
                endcase
            end
            S_EX: state_d = (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM: begin
                // mem_ready takes priority over an expiring wait count
                if (mem_ready) begin
                    wait_d  = '0;
                    state_d = is_lw ? S_WB : S_IF;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q + 8'd1 >= TIMEOUT) state_d = S_TRAP;
                end
            end
            S_WB, S_BR, S_JMP: state_d = S_IF;
            S_TRAP:            state_d = S_TRAP;
        endcase
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    logic       ex_alusrc, ex_extop;
    logic [2:0] ex_alu;

    always_comb begin
        ex_alusrc = 1'b0;
        ex_extop  = 1'b0;
        ex_alu    = 3'b000;
        case (op_q)
            OP_RTYPE: ex_alu = rfunc_alu(func_q);
            OP_ORI: begin
                ex_alu    = 3'b010;
                ex_alusrc = 1'b1;
            end
            OP_ADDIU, OP_LW, OP_SW: begin
                ex_alusrc = 1'b1;
                ex_extop  = 1'b1;
            end
            default: ;
        endcase
    end

    logic       pcwr_c, irwr_c, regwr_c, regdst_c, alusrc_c, extop_c;
    logic       memtoreg_c, memrd_c, memwr_c, done_c;
    logic [1:0] pcsrc_c;
    logic [2:0] alu_c;

    always_comb begin
        pcwr_c     = 1'b0;
        pcsrc_c    = 2'b00;
        irwr_c     = 1'b0;
        regwr_c    = 1'b0;
        regdst_c   = 1'b0;
        alusrc_c   = 1'b0;
        extop_c    = 1'b0;
        memtoreg_c = 1'b0;
        memrd_c    = 1'b0;
        memwr_c    = 1'b0;
        done_c     = 1'b0;
        alu_c      = 3'b000;
        case (state_q)
            S_IF: begin
                irwr_c = 1'b1;
                pcwr_c = 1'b1;
            end
            S_EX: begin
                alu_c    = ex_alu;
                alusrc_c = ex_alusrc;
                extop_c  = ex_extop;
            end
            S_MEM: begin
                alusrc_c = 1'b1;
                memrd_c  = is_lw;
                memwr_c  = is_sw;
                done_c   = is_sw & mem_ready;
            end
            S_WB: begin
                regwr_c    = 1'b1;
                done_c     = 1'b1;
                regdst_c   = is_r;
                memtoreg_c = is_lw;
                alu_c      = ex_alu;
                alusrc_c   = ex_alusrc;
                extop_c    = ex_extop;
            end
            S_BR: begin
                alu_c   = 3'b100;
                extop_c = 1'b1;
                done_c  = 1'b1;
                pcwr_c  = zero;
                pcsrc_c = {1'b0, zero};
            end
            S_JMP: begin
                pcwr_c  = 1'b1;
                pcsrc_c = 2'b10;
                done_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset is asynchronous, so outputs are masked directly rather than waiting for state_q
    always_comb begin
        PCWr     = pcwr_c & ~reset;
        PCSrc    = reset ? 2'b00 : pcsrc_c;
        IRWr     = irwr_c & ~reset;
        RegWr    = regwr_c & ~reset;
        RegDst   = regdst_c & ~reset;
        AluSrc   = alusrc_c & ~reset;
        ExtOp    = extop_c & ~reset;
        MemtoReg = memtoreg_c & ~reset;
        MemRd    = memrd_c & ~reset;
        MemWr    = memwr_c & ~reset;
        Aluctr   = reset ? '0 : ALUCTR_W'(alu_c);
        done     = done_c & ~reset;
        illegal  = illegal_q & ~reset;
        state    = reset ? 3'd0 : state_q;
    end

endmodule

// File: tb/tb_decoding_mc.sv
// Scoreboard bench for decoding_mc: each issued instruction pushes its expected
// outcome summary; a negedge monitor accumulates the DUT's behaviour and compares.
module tb_decoding_mc;

    localparam int AW = 5;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    op, func;
    logic          zero, mem_ready;
    logic          PCWr, IRWr, RegWr, RegDst, AluSrc, ExtOp, MemtoReg, MemRd, MemWr;
    logic          done, illegal;
    logic [1:0]    PCSrc;
    logic [AW-1:0] Aluctr;
    logic [2:0]    state;

    decoding_mc #(.ALUCTR_W(AW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr),
        .RegWr(RegWr), .RegDst(RegDst), .AluSrc(AluSrc), .ExtOp(ExtOp),
        .MemtoReg(MemtoReg), .MemRd(MemRd), .MemWr(MemWr), .Aluctr(Aluctr),
        .done(done), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Per-instruction outcome: event counts over its lifetime plus a snapshot of the final cycle
    typedef struct packed {
        logic          trap;
        logic [7:0]    cycles;
        logic [3:0]    n_pcwr;
        logic [3:0]    n_irwr;
        logic [3:0]    n_regwr;
        logic [7:0]    n_memrd;
        logic [7:0]    n_memwr;
        logic [AW-1:0] alu_ex;
        logic          regdst;
        logic          memtoreg;
        logic [1:0]    pcsrc;
        logic [AW-1:0] alu;
        logic          alusrc;
        logic          extop;
        logic          pcwr;
        logic [2:0]    st;
    } txn_t;

    int   checks = 0;
    int   errors = 0;
    txn_t expq[$];

    function automatic txn_t model(input logic [5:0] o, input logic [5:0] f, input int n, input logic z);
        txn_t e;
        bit   ill;
        int   ra;
        e = '0;
        e.n_irwr = 4'd1;
        e.n_pcwr = 4'd1;
        ill = 0;
        ra  = 0;
        case (o)
            6'h00: begin
                case (f)
                    6'h20: ra = 1;  // add
                    6'h22: ra = 5;  // sub
                    6'h23: ra = 4;  // subu
                    6'h24: ra = 3;  // and
                    6'h2a: ra = 7;  // slt
                    6'h2b: ra = 6;  // sltu
                    default: ill = 1;
                endcase
                if (!ill) begin
                    e.cycles = 8'd4; e.n_regwr = 4'd1; e.regdst = 1'b1;
                    e.alu = AW'(ra); e.alu_ex = AW'(ra); e.st = 3'd4;
                end
            end
            6'h0d: begin
                e.cycles = 8'd4; e.n_regwr = 4'd1; e.alu = AW'(2); e.alu_ex = AW'(2);
                e.alusrc = 1'b1; e.st = 3'd4;
            end
            6'h09: begin
                e.cycles = 8'd4; e.n_regwr = 4'd1; e.alusrc = 1'b1; e.extop = 1'b1; e.st = 3'd4;
            end
            6'h23: begin
                if (n >= TO) begin
                    e.trap = 1'b1; e.cycles = 8'(3 + TO + 1); e.n_memrd = 8'(TO); e.st = 3'd7;
                end else begin
                    e.cycles = 8'(5 + n); e.n_memrd = 8'(n + 1); e.n_regwr = 4'd1;
                    e.memtoreg = 1'b1; e.alusrc = 1'b1; e.extop = 1'b1; e.st = 3'd4;
                end
            end
            6'h2b: begin
                if (n >= TO) begin
                    e.trap = 1'b1; e.cycles = 8'(3 + TO + 1); e.n_memwr = 8'(TO); e.st = 3'd7;
                end else begin
                    e.cycles = 8'(4 + n); e.n_memwr = 8'(n + 1); e.alusrc = 1'b1; e.st = 3'd3;
                end
            end
            6'h04: begin
                e.cycles = 8'd3; e.n_pcwr = 4'(1 + int'(z)); e.pcwr = z; e.pcsrc = {1'b0, z};
                e.alu = AW'(4); e.alu_ex = AW'(4); e.extop = 1'b1; e.st = 3'd5;
            end
            6'h02: begin
                e.cycles = 8'd3; e.n_pcwr = 4'd2; e.pcwr = 1'b1; e.pcsrc = 2'b10; e.st = 3'd6;
            end
            default: ill = 1;
        endcase
        if (ill) begin
            e.trap = 1'b1; e.cycles = 8'd3; e.st = 3'd7;
        end
        return e;
    endfunction

    int   idx = 0;
    txn_t acc = '0;
    txn_t exp_t;
    bit   trapped = 0;

    always @(negedge clk) begin
        if (reset) begin
            idx = 0; acc = '0; trapped = 0;
        end else if (trapped) begin
            checks++;
            if ({PCWr, IRWr, RegWr, MemWr, MemRd, done, PCSrc} !== 8'h00 || illegal !== 1'b1 || state !== 3'd7) begin
                errors++;
                $display("FAIL trap_hold got en=%b ill=%b st=%0d exp en=0 ill=1 st=7",
                         {PCWr, IRWr, RegWr, MemWr, MemRd, done, PCSrc}, illegal, state);
            end
        end else begin
            checks++;
            if (Aluctr[AW-1:3] !== '0) begin
                errors++;
                $display("FAIL alu_upper got %b exp 0", Aluctr[AW-1:3]);
            end
            if (idx == 1) begin
                checks++;
                if ({PCWr, IRWr, RegWr, MemWr} !== 4'b0000) begin
                    errors++;
                    $display("FAIL id_write_en got %b exp 0000", {PCWr, IRWr, RegWr, MemWr});
                end
            end
            if (idx == 2) acc.alu_ex = Aluctr;
            acc.n_pcwr  = acc.n_pcwr + 4'(PCWr);
            acc.n_irwr  = acc.n_irwr + 4'(IRWr);
            acc.n_regwr = acc.n_regwr + 4'(RegWr);
            acc.n_memrd = acc.n_memrd + 8'(MemRd);
            acc.n_memwr = acc.n_memwr + 8'(MemWr);
            idx++;
            if (done || illegal) begin
                acc.trap = illegal; acc.cycles = 8'(idx); acc.regdst = RegDst;
                acc.memtoreg = MemtoReg; acc.pcsrc = PCSrc; acc.alu = Aluctr;
                acc.alusrc = AluSrc; acc.extop = ExtOp; acc.pcwr = PCWr; acc.st = state;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_end got %h exp none", acc);
                end else begin
                    exp_t = expq.pop_front();
                    if (acc !== exp_t) begin
                        errors++;
                        $display("FAIL txn got %h exp %h", acc, exp_t);
                    end
                end
                trapped = illegal;
                idx = 0; acc = '0;
            end else if (idx > 64) begin
                checks++; errors++;
                $display("FAIL stall got %0d cycles exp done/trap", idx);
                idx = 0; acc = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({PCWr, PCSrc, IRWr, RegWr, RegDst, AluSrc, ExtOp, MemtoReg, MemRd, MemWr, Aluctr, done, illegal, state} !== '0) begin
            errors++;
            $display("FAIL async_reset got %b exp 0",
                     {PCWr, PCSrc, IRWr, RegWr, RegDst, AluSrc, ExtOp, MemtoReg, MemRd, MemWr, Aluctr, done, illegal, state});
        end
        expq.delete();
        step();
        reset = 1'b0;
    endtask

    // zsel < 0 picks a random zero flag for the branch cycle
    task automatic run(input logic [5:0] o, input logic [5:0] f, input int n, input int zsel);
        logic zb;
        txn_t e;
        bit   mem_cls;
        zb = (zsel < 0) ? 1'($urandom) : zsel[0];
        e = model(o, f, n, zb);
        expq.push_back(e);
        mem_cls = (o == 6'h23) || (o == 6'h2b);
        op = o;
        func = f;
        for (int k = 0; k < int'(e.cycles); k++) begin
            zero = (k == 2) ? zb : 1'($urandom);
            if (mem_cls && k >= 3) mem_ready = (k == 3 + n);
            else                   mem_ready = 1'($urandom);
            step();
        end
        if (e.trap) begin
            for (int k = 0; k < 20; k++) begin
                op = 6'($urandom); func = 6'($urandom);
                zero = 1'($urandom); mem_ready = 1'($urandom);
                step();
            end
            do_reset();
        end
    endtask

    task automatic mid_mem_reset();
        op = 6'h23;
        func = 6'($urandom);
        for (int k = 0; k < 6; k++) begin
            zero = 1'($urandom);
            mem_ready = (k < 3) ? 1'($urandom) : 1'b0;
            step();
        end
        checks++;
        if (MemRd !== 1'b1 || state !== 3'd3) begin
            errors++;
            $display("FAIL mid_mem got rd=%b st=%0d exp rd=1 st=3", MemRd, state);
        end
        do_reset();
    endtask

    logic [5:0] rfuncs[6] = '{6'h20, 6'h22, 6'h23, 6'h24, 6'h2a, 6'h2b};
    logic [5:0] iops[7]   = '{6'h00, 6'h0d, 6'h09, 6'h23, 6'h2b, 6'h04, 6'h02};

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] ro, rf;
        int         rn;
        reset = 1'b1; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({PCWr, PCSrc, IRWr, RegWr, MemRd, MemWr, Aluctr, done, illegal, state} !== '0) begin
            errors++;
            $display("FAIL reset_state got %b exp 0",
                     {PCWr, PCSrc, IRWr, RegWr, MemRd, MemWr, Aluctr, done, illegal, state});
        end
        reset = 1'b0;

        run(6'h00, 6'h20, 0, -1);   // add
        run(6'h23, 6'h00, 3, -1);   // lw, 3 wait cycles
        run(6'h04, 6'h00, 0, 1);    // beq taken
        run(6'h04, 6'h00, 0, 0);    // beq not taken
        run(6'h02, 6'h00, 0, -1);   // j
        run(6'h3f, 6'h00, 0, -1);   // illegal op
        run(6'h00, 6'h01, 0, -1);   // illegal func
        run(6'h2b, 6'h00, 15, -1);  // sw timeout
        run(6'h2b, 6'h00, 14, -1);  // sw ready on last permitted cycle
        run(6'h23, 6'h00, 40, -1);  // lw timeout
        run(6'h00, 6'h24, 0, -1);   // and
        mid_mem_reset();
        run(6'h0d, 6'h00, 0, -1);   // ori
        run(6'h09, 6'h00, 0, -1);   // addiu

        for (int i = 0; i < 150; i++) begin
            ro = iops[$urandom_range(0, 6)];
            rf = rfuncs[$urandom_range(0, 5)];
            if ($urandom_range(0, 15) == 0) ro = 6'($urandom);
            if ($urandom_range(0, 15) == 0) rf = 6'($urandom);
            rn = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 4);
            run(ro, rf, rn, -1);
        end

        step();
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL pending got %0d exp 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
